// File: rtl/code_change_if.sv
// Keypad/lock-side signal bundle for the code-change sequencer.
// master = the sequencer, slave = the lock logic / keypad side.
interface code_change_if #(
    parameter int CODE_DIGITS = 4
);
    logic                       unlock;
    logic                       CleanPBPulse;
    logic                       newKey;
    logic [4:0]                 keyCode;
    logic                       code_wr;
    logic [4*CODE_DIGITS-1:0]   code_wdata;
    logic                       busy;
    logic [1:0]                 stage;
    logic [3:0]                 digit_cnt;
    logic                       err;

    modport master (
        input  unlock, CleanPBPulse, newKey, keyCode,
        output code_wr, code_wdata, busy, stage, digit_cnt, err
    );

    modport slave (
        output unlock, CleanPBPulse, newKey, keyCode,
        input  code_wr, code_wdata, busy, stage, digit_cnt, err
    );
endinterface

// File: rtl/code_change_ctrl.sv
// Combination-lock code change sequencer: double entry, compare, one-cycle commit strobe.
// Optional entry inactivity timeout enabled by defining CODE_CHG_TIMEOUT_EN.
module code_change_ctrl #(
    parameter int CODE_DIGITS    = 4,
    parameter int ERR_CYCLES     = 5_000_000,
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic          clk5,
    input  logic          reset,
    code_change_if.master bus
);
    localparam int W     = 4 * CODE_DIGITS;
    localparam int ERR_W = $clog2(ERR_CYCLES + 1);

    generate
        if (CODE_DIGITS < 1 || CODE_DIGITS > 8 || ERR_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("code_change_ctrl: parameter out of range");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_ENTER1, S_ENTER2, S_COMPARE, S_ERROR
    } state_t;

    state_t             state_reg, state_next;
    logic [W-1:0]       buf1_reg, buf2_reg, code_wdata_reg;
    logic [3:0]         digit_cnt_reg, digit_cnt_next;
    logic [ERR_W-1:0]   err_cnt_reg;
    logic               code_wr_reg, code_wr_next;
    logic               busy_reg, busy_next;
    logic [1:0]         stage_reg, stage_next;
    logic               err_reg, err_next;

    logic key_digit, key_clear, in_entry, abort_req, last_digit, match, timeout_hit, buf_clear;

    assign key_digit  = bus.newKey && (bus.keyCode <= 5'd9);
    assign key_clear  = bus.newKey && (bus.keyCode == 5'h0C);
    assign in_entry   = (state_reg == S_ENTER1) || (state_reg == S_ENTER2);
    assign abort_req  = bus.CleanPBPulse || !bus.unlock || timeout_hit;
    assign last_digit = key_digit && (digit_cnt_reg == 4'(CODE_DIGITS - 1));
    assign match      = (buf1_reg == buf2_reg);

`ifdef CODE_CHG_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr_reg;

    assign timeout_hit = in_entry && (tmr_reg == TMR_W'(TIMEOUT_CYCLES - 1));

    // Reloads on state entry and on every accepted digit or CLEAR; ignored keys do not count.
    always_ff @(posedge clk5) begin
        if (reset || !in_entry || (state_next != state_reg) || key_digit || key_clear) begin
            tmr_reg <= '0;
        end else if (tmr_reg != TMR_W'(TIMEOUT_CYCLES - 1)) begin
            tmr_reg <= tmr_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk5) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort takes priority over any same-cycle key
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.CleanPBPulse && bus.unlock) state_next = S_ENTER1;
            end
            S_ENTER1: begin
                if (abort_req)       state_next = S_IDLE;
                else if (key_clear)  state_next = S_ENTER1;
                else if (last_digit) state_next = S_ENTER2;
            end
            S_ENTER2: begin
                if (abort_req)       state_next = S_IDLE;
                else if (key_clear)  state_next = S_ENTER1;
                else if (last_digit) state_next = S_COMPARE;
            end
            S_COMPARE: begin
                if (abort_req)  state_next = S_IDLE;
                else if (match) state_next = S_IDLE;
                else            state_next = S_ERROR;
            end
            S_ERROR: begin
                if (err_cnt_reg == ERR_W'(ERR_CYCLES - 1)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: values loaded into the output registers on the coming edge
    always_comb begin
        code_wr_next   = (state_reg == S_COMPARE) && !abort_req && match;
        busy_next      = (state_next != S_IDLE);
        err_next       = (state_next == S_ERROR);
        stage_next     = 2'd0;
        digit_cnt_next = digit_cnt_reg;
        case (state_next)
            S_ENTER1:  stage_next = 2'd1;
            S_ENTER2:  stage_next = 2'd2;
            S_COMPARE: stage_next = 2'd2;
            S_ERROR:   stage_next = 2'd3;
            default:   stage_next = 2'd0;
        endcase
        if (state_next == S_IDLE || state_next == S_ERROR) begin
            digit_cnt_next = 4'd0;
        end else if (in_entry && !abort_req) begin
            if (key_clear) begin
                digit_cnt_next = 4'd0;
            end else if (key_digit) begin
                if (last_digit && state_reg == S_ENTER1)
                    digit_cnt_next = 4'd0;
                else if (digit_cnt_reg < 4'(CODE_DIGITS))
                    digit_cnt_next = digit_cnt_reg + 4'd1;
            end
        end
    end

    assign buf_clear = (state_next == S_IDLE) || (in_entry && !abort_req && key_clear);

    always_ff @(posedge clk5) begin
        if (reset) begin
            buf1_reg       <= '0;
            buf2_reg       <= '0;
            code_wdata_reg <= '0;
            digit_cnt_reg  <= '0;
            err_cnt_reg    <= '0;
            code_wr_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            stage_reg      <= 2'd0;
            err_reg        <= 1'b0;
        end else begin
            code_wr_reg   <= code_wr_next;
            busy_reg      <= busy_next;
            stage_reg     <= stage_next;
            err_reg       <= err_next;
            digit_cnt_reg <= digit_cnt_next;

            if (code_wr_next) code_wdata_reg <= buf2_reg;

            if (buf_clear) begin
                buf1_reg <= '0;
                buf2_reg <= '0;
            end else if (key_digit && !abort_req) begin
                if (state_reg == S_ENTER1) buf1_reg <= (buf1_reg << 4) | W'(bus.keyCode[3:0]);
                if (state_reg == S_ENTER2) buf2_reg <= (buf2_reg << 4) | W'(bus.keyCode[3:0]);
            end

            if (state_reg == S_ERROR && err_cnt_reg != ERR_W'(ERR_CYCLES - 1))
                err_cnt_reg <= err_cnt_reg + 1'b1;
            else
                err_cnt_reg <= '0;
        end
    end

    assign bus.code_wr    = code_wr_reg;
    assign bus.code_wdata = code_wdata_reg;
    assign bus.busy       = busy_reg;
    assign bus.stage      = stage_reg;
    assign bus.digit_cnt  = digit_cnt_reg;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_code_change_ctrl.sv
// Directed bench for code_change_ctrl; commits are checked by a scoreboard monitor.
module tb_code_change_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    code_change_if #(.CODE_DIGITS(4)) bus ();

    code_change_ctrl #(
        .CODE_DIGITS(4), .ERR_CYCLES(20), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk5(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;
    exp_t expq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: every code_wr pulse must match the next expected commit, data and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.code_wr) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_code_wr: got data %0h at cycle %0d, required no strobe",
                         bus.code_wdata, cyc);
            end else begin
                e = expq.pop_front();
                $display("commit data=%h cycle=%0d", bus.code_wdata, cyc);
                chk("code_wr_cycle", cyc, e.cyc);
                chk("code_wdata", {16'd0, bus.code_wdata}, {16'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pb();
        bus.CleanPBPulse = 1'b1;
        tick();
        bus.CleanPBPulse = 1'b0;
    endtask

    task automatic key(input logic [4:0] k);
        bus.newKey  = 1'b1;
        bus.keyCode = k;
        tick();
        bus.newKey  = 1'b0;
    endtask

    task automatic keys4(input logic [15:0] c);
        for (int i = 0; i < 4; i++) key({1'b0, c[15-4*i -: 4]});
    endtask

    // Strobe appears one edge after the compare cycle, i.e. two cycles after the last key.
    task automatic expect_commit(input logic [15:0] c);
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = c;
        expq.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_code_wr"}, {31'd0, bus.code_wr}, 32'd0);
        chk({tag, "_code_wdata"}, {16'd0, bus.code_wdata}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_stage"}, {30'd0, bus.stage}, 32'd0);
        chk({tag, "_digit_cnt"}, {28'd0, bus.digit_cnt}, 32'd0);
        chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        bus.unlock = 1'b0;
        bus.CleanPBPulse = 1'b0;
        bus.newKey = 1'b0;
        bus.keyCode = 5'd0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // 1: matching entries commit 1234
        $display("test1 match 1234");
        bus.unlock = 1'b1;
        pb();
        chk("t1_stage_enter1", {30'd0, bus.stage}, 32'd1);
        chk("t1_busy", {31'd0, bus.busy}, 32'd1);
        key(5'd1); key(5'd2); key(5'd3);
        chk("t1_cnt3", {28'd0, bus.digit_cnt}, 32'd3);
        key(5'd4);
        chk("t1_stage_enter2", {30'd0, bus.stage}, 32'd2);
        chk("t1_cnt_reload", {28'd0, bus.digit_cnt}, 32'd0);
        keys4(16'h1234);
        expect_commit(16'h1234);
        chk("t1_stage_compare", {30'd0, bus.stage}, 32'd2);
        tick();
        tick();
        chk("t1_busy_done", {31'd0, bus.busy}, 32'd0);
        chk("t1_stage_done", {30'd0, bus.stage}, 32'd0);
        chk("t1_wdata_hold", {16'd0, bus.code_wdata}, 32'h1234);

        // 2: mismatch -> ERROR for 20 cycles; PB, keys and unlock drop ignored meanwhile
        $display("test2 mismatch 1234/1235");
        pb();
        keys4(16'h1234);
        keys4(16'h1235);
        tick();
        chk("t2_stage_error", {30'd0, bus.stage}, 32'd3);
        n = 0;
        while (bus.err && n < 100) begin
            bus.CleanPBPulse = (n == 5);
            bus.newKey = (n == 6);
            bus.keyCode = 5'h0C;
            bus.unlock = !(n >= 8 && n < 12);
            tick();
            n++;
        end
        bus.CleanPBPulse = 1'b0;
        bus.newKey = 1'b0;
        bus.unlock = 1'b1;
        chk("t2_err_cycles", n, 32'd20);
        chk("t2_stage_idle", {30'd0, bus.stage}, 32'd0);
        chk("t2_wdata_kept", {16'd0, bus.code_wdata}, 32'h1234);

        // 3: PB while locked is ignored; unlock drop aborts an entry
        $display("test3 locked PB and unlock drop");
        bus.unlock = 1'b0;
        pb();
        chk("t3_locked_stage", {30'd0, bus.stage}, 32'd0);
        chk("t3_locked_busy", {31'd0, bus.busy}, 32'd0);
        bus.unlock = 1'b1;
        pb();
        key(5'd7);
        chk("t3_cnt1", {28'd0, bus.digit_cnt}, 32'd1);
        bus.unlock = 1'b0;
        tick();
        chk("t3_abort_stage", {30'd0, bus.stage}, 32'd0);
        chk("t3_abort_busy", {31'd0, bus.busy}, 32'd0);
        bus.unlock = 1'b1;
        tick();

        // 4: CLEAR restarts, ignored key leaves the count alone
        $display("test4 clear and commit 5678");
        pb();
        key(5'd9); key(5'd9);
        chk("t4_cnt2", {28'd0, bus.digit_cnt}, 32'd2);
        key(5'h0C);
        chk("t4_clear_stage", {30'd0, bus.stage}, 32'd1);
        chk("t4_clear_cnt", {28'd0, bus.digit_cnt}, 32'd0);
        key(5'd5); key(5'd6); key(5'h0A);
        chk("t4_ignored_key", {28'd0, bus.digit_cnt}, 32'd2);
        key(5'd7); key(5'd8);
        keys4(16'h5678);
        expect_commit(16'h5678);
        tick();
        tick();
        chk("t4_wdata", {16'd0, bus.code_wdata}, 32'h5678);

        // 5: inactivity during ENTER1
        $display("test5 idle entry");
        pb();
        key(5'd3);
`ifdef CODE_CHG_TIMEOUT_EN
        n = 0;
        while (bus.stage != 2'd0 && n < 300) begin
            tick();
            n++;
        end
        chk("t5_timeout_cycles", n, 32'd100);
        chk("t5_err", {31'd0, bus.err}, 32'd0);
`else
        repeat (1000) tick();
        chk("t5_still_enter1", {30'd0, bus.stage}, 32'd1);
        chk("t5_cnt_kept", {28'd0, bus.digit_cnt}, 32'd1);
        pb();
        chk("t5_pb_abort", {30'd0, bus.stage}, 32'd0);
`endif

        // 6: PB with final digit aborts; reset mid-ERROR
        $display("test6 abort beats final digit, reset in ERROR");
        pb();
        keys4(16'h4321);
        key(5'd4); key(5'd3); key(5'd2);
        bus.CleanPBPulse = 1'b1;
        key(5'd1);
        bus.CleanPBPulse = 1'b0;
        chk("t6_abort_stage", {30'd0, bus.stage}, 32'd0);
        chk("t6_abort_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        tick();
        pb();
        keys4(16'h1111);
        keys4(16'h2222);
        tick();
        repeat (3) tick();
        chk("t6_in_error", {31'd0, bus.err}, 32'd1);
        reset = 1'b1;
        tick();
        chk_all_zero("t6_reset");
        reset = 1'b0;
        repeat (3) tick();
        chk("t6_queue_empty", expq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/code_change_ctrl.md
Name: code_change_ctrl

Overview:
Sequences reprogramming of the combination-lock code. Arms only while the lock reports unlocked. Collects a new code twice from the keypad interface and compares the two entries. On a match, issues a one-cycle write strobe with the new code to the lock logic's code register; on a mismatch, aborts with a timed error flag. Sits beside the lock logic in the top level and shares the keypad and push-button pulses with it.

Parameters:
CODE_DIGITS, 4, number of digits per code entry (1..8)
ERR_CYCLES, 5_000_000, cycles the err output stays high after a mismatch (1 s at 5 MHz)
TIMEOUT_CYCLES, 25_000_000, idle cycles without a key before an entry aborts (5 s at 5 MHz)

Ports:
clk5  in  1  5 MHz system clock
reset  in  1  synchronous, active-high reset
unlock  in  1  lock-open status from the lock logic; change permitted only while 1
CleanPBPulse  in  1  one-cycle debounced push-button pulse
newKey  in  1  one-cycle pulse per keypress
keyCode  in  5  key code, valid while newKey=1; 0..9 = digits, 5'h0C = CLEAR, all other values ignored
code_wr  out  1  one-cycle strobe: commit code_wdata
code_wdata  out  4*CODE_DIGITS  committed code, BCD, first-entered digit in the MS nibble
busy  out  1  high in any state other than IDLE
stage  out  2  0=IDLE, 1=ENTER1, 2=ENTER2, 3=ERROR
digit_cnt  out  4  digits captured in the current entry
err  out  1  high during ERROR

Behaviour:
- Reset: all outputs 0, state IDLE, both entry buffers cleared, timers cleared.
- Everything is registered on clk5. Outputs are driven from registers.
- IDLE: when CleanPBPulse=1 and unlock=1, go to ENTER1 and set digit_cnt=0.
- ENTER1/ENTER2 digit capture: a newKey with keyCode<=9 shifts the digit into that stage's buffer (buf <= {buf, digit}) and increments digit_cnt.
- When the CODE_DIGITS-th digit is captured in ENTER1, go to ENTER2 on the next edge with digit_cnt=0.
- When the CODE_DIGITS-th digit is captured in ENTER2, compare on the following cycle (internal COMPARE state, stage still reads 2).
  - Match: code_wr=1 for exactly one cycle, code_wdata updated in the same cycle, then IDLE. Latency is 2 cycles from the last newKey to code_wr.
  - Mismatch: go to ERROR.
- CLEAR key in ENTER1 or ENTER2: clear both buffers, go to ENTER1, digit_cnt=0.
- Non-digit, non-CLEAR keys: ignored. They do not restart the timeout.
- Abort conditions in ENTER1, ENTER2 or COMPARE: CleanPBPulse=1 or unlock=0. Abort returns to IDLE, clears the buffers, and issues no code_wr.
- Simultaneous events:
  - Abort beats any same-cycle newKey, including the final digit.
  - CleanPBPulse in IDLE while unlock=0 is ignored.
- ERROR: err=1 for ERR_CYCLES cycles, then IDLE. Keys and PB are ignored during ERROR. unlock=0 does not shorten ERROR.
- code_wdata holds its last committed value between commits. It is never changed by an abort, a mismatch or CLEAR; only reset clears it.
- digit_cnt never exceeds CODE_DIGITS. Counters saturate and do not wrap.
- A reset asserted mid-entry or mid-ERROR returns every output to its reset value on the next edge.

Optional Feature:
CODE_CHG_TIMEOUT_EN.
- Defined: a timer counts cycles in ENTER1/ENTER2. It reloads to 0 on every accepted digit or CLEAR and on state entry. Reaching TIMEOUT_CYCLES-1 aborts to IDLE exactly like a PB abort (no code_wr, err stays 0).
- Undefined: no timer logic is present and entries wait indefinitely. TIMEOUT_CYCLES is unused.

Test Plan:
(Bench overrides ERR_CYCLES=20, TIMEOUT_CYCLES=100, CODE_DIGITS=4.)
1. unlock=1, PB pulse, keys 1,2,3,4, then 1,2,3,4 -> exactly one code_wr pulse 2 cycles after the last newKey, code_wdata=16'h1234, then busy=0 and stage=0.
2. unlock=1, PB pulse, keys 1,2,3,4, then 1,2,3,5 -> no code_wr, stage=3, err=1 for 20 cycles, then IDLE; code_wdata keeps its previous value.
3. PB pulse with unlock=0 -> stays IDLE, busy=0. Then unlock=1, PB pulse, key 7, drop unlock -> IDLE next edge, no code_wr.
4. Entry 9,9, CLEAR, then 5,6,7,8, 5,6,7,8 -> code_wdata=16'h5678. Key code 5'h0A mid-entry -> digit_cnt unchanged.
5. With CODE_CHG_TIMEOUT_EN: enter ENTER1, press key 3, then 100 idle cycles -> IDLE, no code_wr, err=0. Without the macro: still in ENTER1 after 1000 cycles.
6. Final ENTER2 digit and CleanPBPulse in the same cycle -> abort to IDLE, no code_wr. Reset asserted mid-ERROR -> all outputs 0 next edge.
